// File: rtl/roc_encoder_param_if.sv
// Pixel stream and AER link of the rank-order-coding encoder.
// The encoder uses the master modport; the pixel source / AER sink uses slave.
interface roc_encoder_param_if #(
    parameter int PIXEL_BITS = 8,
    parameter int AER_WIDTH  = 10
);
    logic                  PIX_VALID;
    logic [PIXEL_BITS-1:0] PIX_DATA;
    logic                  PIX_READY;
    logic                  AER_VALID;
    logic [AER_WIDTH-1:0]  AER_ADDR;
    logic                  AER_READY;

    modport master (
        input  PIX_VALID, PIX_DATA, AER_READY,
        output PIX_READY, AER_VALID, AER_ADDR
    );

    modport slave (
        output PIX_VALID, PIX_DATA, AER_READY,
        input  PIX_READY, AER_VALID, AER_ADDR
    );
endinterface

// File: rtl/roc_encoder_param.sv
// Rank-order-coding encoder: loads an image, counting-sorts pixels brightest first and
// streams preamble + pixel indices as AER words. Optional macro ROC_THRESHOLD_EN adds a cut-off.
module roc_encoder_param #(
    parameter int          IMAGE_SIZE    = 256,
    parameter int          PIXEL_BITS    = 8,
    parameter int          AER_WIDTH     = 10,
    parameter int          PREAMBLE_LEN  = 2,
    parameter int unsigned PREAMBLE_CODE = 'h1FF,
    parameter int          MAX_SPIKES    = IMAGE_SIZE
) (
    input  logic                              CLK,
    input  logic                              RST,
`ifdef ROC_THRESHOLD_EN
    input  logic [PIXEL_BITS-1:0]             THRESHOLD,
`endif
    input  logic                              NEW_IMAGE,
    input  logic                              ABORT,
    roc_encoder_param_if.master               bus,
    output logic                              ENCODER_RDY,
    output logic                              DONE,
    output logic [$clog2(IMAGE_SIZE+1)-1:0]   SPIKE_COUNT
);

    localparam int IDX_W    = $clog2(IMAGE_SIZE);
    localparam int CNT_W    = $clog2(IMAGE_SIZE + 1);
    localparam int NUM_VALS = 1 << PIXEL_BITS;
    localparam int PRE_W    = (PREAMBLE_LEN < 1) ? 1 : $clog2(PREAMBLE_LEN + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(IMAGE_SIZE - 1);
    localparam logic [PIXEL_BITS-1:0] TOP_VAL  = PIXEL_BITS'(NUM_VALS - 2);
    localparam logic [CNT_W-1:0]      MAX_N    = CNT_W'(MAX_SPIKES);
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [AER_WIDTH-1:0]  PRE_WORD = AER_WIDTH'(PREAMBLE_CODE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HIST, S_CSUM, S_SORT, S_PREAMBLE, S_EMIT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PIXEL_BITS-1:0]   val_q, val_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic [CNT_W-1:0]        spike_q, spike_d;
    logic                    aer_valid_q, aer_valid_d;
    logic [AER_WIDTH-1:0]    aer_addr_q, aer_addr_d;
    logic                    word_is_idx_q, word_is_idx_d;
    logic                    pix_ready_q, pix_ready_d;
    logic                    rdy_q, rdy_d;
    logic                    done_q, done_d;

    logic [PIXEL_BITS-1:0]   pix_buf_q [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0]   pix_buf_d [IMAGE_SIZE];
    logic [CNT_W-1:0]        hist_q    [NUM_VALS];
    logic [CNT_W-1:0]        hist_d    [NUM_VALS];
    logic [IDX_W-1:0]        sorted_q  [IMAGE_SIZE];
    logic [IDX_W-1:0]        sorted_d  [IMAGE_SIZE];

    logic                    xfer;
    logic                    slot_free;
    logic [PIXEL_BITS-1:0]   cur_pix;
    logic [CNT_W-1:0]        sort_pos;
    logic [IDX_W-1:0]        emit_idx;
    logic                    below_thr;

    assign xfer      = aer_valid_q & bus.AER_READY;
    // A new word may be launched when the output register is empty or draining this cycle.
    assign slot_free = ~aer_valid_q | bus.AER_READY;
    assign cur_pix   = pix_buf_q[idx_q];
    assign sort_pos  = hist_q[cur_pix] - 1'b1;
    assign emit_idx  = sorted_q[IDX_W'(n_q)];

`ifdef ROC_THRESHOLD_EN
    logic [PIXEL_BITS-1:0] thr_q, thr_d;

    always_comb begin
        thr_d = thr_q;
        if (state_q == S_IDLE && NEW_IMAGE) thr_d = THRESHOLD;
    end

    always_ff @(posedge CLK) begin
        if (RST) thr_q <= '0;
        else     thr_q <= thr_d;
    end

    assign below_thr = pix_buf_q[emit_idx] < thr_q;
`else
    assign below_thr = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        val_d         = val_q;
        pre_d         = pre_q;
        n_d           = n_q;
        spike_d       = spike_q;
        aer_valid_d   = aer_valid_q;
        aer_addr_d    = aer_addr_q;
        word_is_idx_d = word_is_idx_q;
        pix_buf_d     = pix_buf_q;
        hist_d        = hist_q;
        sorted_d      = sorted_q;

        if (xfer && word_is_idx_q) spike_d = spike_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (NEW_IMAGE) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    spike_d = '0;
                end
            end
            S_LOAD: begin
                if (bus.PIX_VALID && pix_ready_q) begin
                    pix_buf_d[idx_q] = bus.PIX_DATA;
                    idx_d            = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_HIST;
                        idx_d   = '0;
                        for (int v = 0; v < NUM_VALS; v++)   hist_d[v]   = '0;
                        for (int s = 0; s < IMAGE_SIZE; s++) sorted_d[s] = '0;
                    end
                end
            end
            S_HIST: begin
                hist_d[cur_pix] = hist_q[cur_pix] + 1'b1;
                idx_d           = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_CSUM;
                    val_d   = TOP_VAL;
                end
            end
            S_CSUM: begin
                // Suffix sum: afterwards hist[v] counts pixels with intensity >= v.
                hist_d[val_q] = hist_q[val_q] + hist_q[val_q + 1'b1];
                if (val_q == '0) begin
                    state_d = S_SORT;
                    idx_d   = LAST_IDX;
                end else begin
                    val_d = val_q - 1'b1;
                end
            end
            S_SORT: begin
                // Walking indices downward fills each intensity group from its end,
                // which leaves equal intensities in ascending index order.
                sorted_d[IDX_W'(sort_pos)] = idx_q;
                hist_d[cur_pix]            = sort_pos;
                if (idx_q == '0) begin
                    state_d = (PREAMBLE_LEN == 0) ? S_EMIT : S_PREAMBLE;
                    pre_d   = '0;
                    n_d     = '0;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (slot_free) begin
                    aer_valid_d   = 1'b1;
                    aer_addr_d    = PRE_WORD;
                    word_is_idx_d = 1'b0;
                    pre_d         = pre_q + 1'b1;
                    if (pre_q == PRE_LAST) state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (slot_free) begin
                    if (n_q == MAX_N || below_thr) begin
                        aer_valid_d   = 1'b0;
                        word_is_idx_d = 1'b0;
                        state_d       = S_DONE;
                    end else begin
                        aer_valid_d   = 1'b1;
                        aer_addr_d    = AER_WIDTH'(emit_idx);
                        word_is_idx_d = 1'b1;
                        n_d           = n_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (ABORT && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            aer_valid_d   = 1'b0;
            word_is_idx_d = 1'b0;
        end

        pix_ready_d = (state_d == S_LOAD);
        rdy_d       = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            val_q         <= '0;
            pre_q         <= '0;
            n_q           <= '0;
            spike_q       <= '0;
            aer_valid_q   <= 1'b0;
            aer_addr_q    <= '0;
            word_is_idx_q <= 1'b0;
            pix_ready_q   <= 1'b0;
            rdy_q         <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            val_q         <= val_d;
            pre_q         <= pre_d;
            n_q           <= n_d;
            spike_q       <= spike_d;
            aer_valid_q   <= aer_valid_d;
            aer_addr_q    <= aer_addr_d;
            word_is_idx_q <= word_is_idx_d;
            pix_ready_q   <= pix_ready_d;
            rdy_q         <= rdy_d;
            done_q        <= done_d;
        end
    end

    // NOTE: storage arrays have no reset; histogram and sort buffer are cleared on HIST entry
    // and the pixel buffer is always fully written before it is read.
    always_ff @(posedge CLK) begin
        pix_buf_q <= pix_buf_d;
        hist_q    <= hist_d;
        sorted_q  <= sorted_d;
    end

    assign bus.PIX_READY = pix_ready_q;
    assign bus.AER_VALID = aer_valid_q;
    assign bus.AER_ADDR  = aer_addr_q;
    assign ENCODER_RDY   = rdy_q;
    assign DONE          = done_q;
    assign SPIKE_COUNT   = spike_q;

endmodule
